// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
//==========================================================================
// Package  : cdb_arbiter_pkg
// Brief    : Shared CDB widths and packet/result types used by cdb, rob and rs.
// Revision : 1.0 - initial release
//==========================================================================
package cdb_arbiter_pkg;

  localparam int c_xlen      = 32;
  localparam int c_num_fu    = 4;
  localparam int c_rob_tag_w = 5;
  localparam int c_qdepth    = 2;

  typedef struct packed {
    logic                   valid;
    logic [c_rob_tag_w-1:0] tag;
    logic [c_xlen-1:0]      value;
  } cdb_packet_t;

  typedef struct packed {
    logic [c_rob_tag_w-1:0] tag;
    logic [c_xlen-1:0]      value;
  } fu_result_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_fifo.sv
`default_nettype none
//==========================================================================
// Module   : cdb_arbiter_fifo
// Brief    : Single-FU result queue with push, pop, flush, full/empty, head.
// Revision : 1.0 - initial release
//==========================================================================
module cdb_arbiter_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int WIDTH = c_rob_tag_w + c_xlen,
  parameter int DEPTH = c_qdepth
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_cnt_w  = c_addr_w + 1;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic                w_do_push;
  logic                w_do_pop;

  assign full      = (r_count == c_cnt_w'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full && !flush;
  assign w_do_pop  = pop && !empty && !flush;
  assign head_data = r_mem[r_rd_ptr];

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + c_cnt_w'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - c_cnt_w'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
//==========================================================================
// Module   : cdb_arbiter
// Brief    : Queues FU results and round-robin drives one registered CDB packet
//            per cycle. CDB_FIXED_PRIO_EN selects lowest-index-first priority.
// Revision : 1.0 - initial release
//==========================================================================
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = c_num_fu,
  parameter int QDEPTH = c_qdepth,
  parameter int TAG_W  = c_rob_tag_w
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  logic [NUM_FU-1:0]          fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]    fu_tag,
  input  logic [NUM_FU*c_xlen-1:0]   fu_value,
  output logic [NUM_FU-1:0]          fu_ready,
  output logic [TAG_W+c_xlen:0]      cdb_packet
);

  localparam int c_ptr_w = $clog2(NUM_FU);
  localparam int c_ent_w = TAG_W + c_xlen;

  logic [NUM_FU-1:0]  w_full;
  logic [NUM_FU-1:0]  w_empty;
  logic [NUM_FU-1:0]  w_push;
  logic [NUM_FU-1:0]  w_pop;
  logic [c_ent_w-1:0] w_head [NUM_FU];
  logic [c_ptr_w-1:0] w_start;
  logic [c_ptr_w-1:0] w_cand;
  logic [c_ptr_w-1:0] w_grant_idx;
  logic               w_grant_valid;
  logic               r_valid;
  logic [TAG_W-1:0]   r_tag;
  logic [c_xlen-1:0]  r_value;

  assign fu_ready   = {NUM_FU{reset}} & ~w_full;
  assign w_push     = fu_valid & ~w_full & ~{NUM_FU{squash}};
  assign cdb_packet = {r_valid, r_tag, r_value};

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    cdb_arbiter_fifo #(
      .WIDTH (c_ent_w),
      .DEPTH (QDEPTH)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (squash),
      .push      (w_push[i]),
      .pop       (w_pop[i]),
      .push_data ({fu_tag[i*TAG_W +: TAG_W], fu_value[i*c_xlen +: c_xlen]}),
      .full      (w_full[i]),
      .empty     (w_empty[i]),
      .head_data (w_head[i])
    );
  end

`ifdef CDB_FIXED_PRIO_EN
  assign w_start = '0;
`else
  logic [c_ptr_w-1:0] r_rr_ptr;

  assign w_start = r_rr_ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
    end else if (squash) begin
      r_rr_ptr <= '0;
    end else if (w_grant_valid) begin
      r_rr_ptr <= c_ptr_w'(wrap_inc(int'(w_grant_idx), NUM_FU));
    end
  end
`endif

  // Scan from the start pointer, wrapping; the first non-empty queue wins.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    w_cand        = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_cand = c_ptr_w'((int'(w_start) + k) % NUM_FU);
      if (!w_grant_valid && !w_empty[w_cand]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = w_cand;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    if (w_grant_valid && !squash) begin
      w_pop[w_grant_idx] = 1'b1;
    end
  end

  // Tag and value hold when idle so downstream sees a stable bus.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_value <= '0;
    end else if (squash) begin
      r_valid <= 1'b0;
    end else if (w_grant_valid) begin
      r_valid          <= 1'b1;
      {r_tag, r_value} <= w_head[w_grant_idx];
    end else begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
